// File: rtl/wb_mem_responder.sv
// Purpose : Wishbone-style sole slave: word RAM, mailbox address backed by RX/TX FIFOs, sticky error flag.
// Latency : Wb_ack rises WAIT_STATES+1 edges after the sampling edge (same edge when WAIT_STATES=0), plus any stall cycles.
// Backpr. : mailbox reads stall while RX is empty, mailbox writes stall while TX is full; Rx_ready drops when RX is full.
//
// Ports:
//   Clk, Rst                       clock (rising edge), async active-low reset
//   Wb_addr/cs/we/wdata            request from the core; Wb_cs held until Wb_ack
//   Wb_rdata, Wb_ack               registered completion; Wb_rdata is 0 unless a read is acked
//   Rx_valid/Rx_data/Rx_ready      host pushes words the core reads from the mailbox
//   Tx_valid/Tx_data/Tx_ready      host pops words the core wrote to the mailbox
//   Bus_err, Err_clr               sticky decode/alignment error and its synchronous clear

// Purpose : generic FIFO with valid/ready on both sides.
// Latency : a pushed word is visible at pop_dat the cycle after the push edge.
// Backpr. : push_rdy low when full; pop_dat forced to 0 while empty.
module wb_mem_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign push_rdy = (count != (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
  assign push     = push_vld && push_rdy;
  assign pop      = pop_rdy && pop_vld;

  // Pointers are exactly AW bits wide, so they wrap on their own at DEPTH.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module wb_mem_responder #(
  parameter int                  ADDR_SIZE   = 32,
  parameter int                  WORD_SIZE   = 32,
  parameter int                  DEPTH       = 1024,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_SIZE-1:0] MBOX_ADDR  = 32'hFFFF_FFFC,
  parameter int                  WAIT_STATES = 1,
  parameter int                  FIFO_DEPTH  = 4,
  parameter string               INIT_FILE   = ""
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [ADDR_SIZE-1:0] Wb_addr,
  input  logic                 Wb_cs,
  input  logic                 Wb_we,
  input  logic [WORD_SIZE-1:0] Wb_wdata,
  output logic [WORD_SIZE-1:0] Wb_rdata,
  output logic                 Wb_ack,
  input  logic                 Rx_valid,
  input  logic [WORD_SIZE-1:0] Rx_data,
  output logic                 Rx_ready,
  output logic                 Tx_valid,
  output logic [WORD_SIZE-1:0] Tx_data,
  input  logic                 Tx_ready,
  output logic                 Bus_err,
  input  logic                 Err_clr
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_SIZE:0] RAM_BYTES = (ADDR_SIZE+1)'(4 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL, S_ACK} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic                 we_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // In IDLE the live bus is decoded so a zero-wait request can complete on its sampling edge.
  logic [ADDR_SIZE-1:0] cur_addr, off;
  logic                 cur_we;
  logic [WORD_SIZE-1:0] cur_wdata;
  logic                 is_mbox, is_ram, is_err, mbox_ok;
  logic [IDX_W-1:0]     ram_idx;

  assign cur_addr  = (state == S_IDLE) ? Wb_addr  : addr_q;
  assign cur_we    = (state == S_IDLE) ? Wb_we    : we_q;
  assign cur_wdata = (state == S_IDLE) ? Wb_wdata : wdata_q;
  assign off       = cur_addr - BASE_ADDR;
  assign is_mbox   = (cur_addr == MBOX_ADDR);
  assign is_ram    = !is_mbox && (cur_addr >= BASE_ADDR) && ({1'b0, off} < RAM_BYTES)
                     && (cur_addr[1:0] == 2'b00);
  assign is_err    = !is_mbox && !is_ram;
  assign ram_idx   = off[IDX_W+1:2];

  logic                 rx_pop_vld, rx_pop, tx_push_rdy, tx_push;
  logic [WORD_SIZE-1:0] rx_pop_dat;

  assign mbox_ok = !is_mbox || (cur_we ? tx_push_rdy : rx_pop_vld);

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state; dropping Wb_cs while waiting or stalled abandons the request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Wb_cs) begin
        if (WAIT_STATES == 0) state_nxt = mbox_ok ? S_ACK : S_STALL;
        else                  state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!Wb_cs)            state_nxt = S_IDLE;
        else if (cnt == 4'd0)  state_nxt = mbox_ok ? S_ACK : S_STALL;
      end
      S_STALL: begin
        if (!Wb_cs)       state_nxt = S_IDLE;
        else if (mbox_ok) state_nxt = S_ACK;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every side effect is tied to the edge that enters ACK.
  logic                 go_ack, ram_we, err_set;
  logic [WORD_SIZE-1:0] rdata_nxt;

  always_comb begin
    go_ack    = (state_nxt == S_ACK);
    ram_we    = go_ack && cur_we && is_ram;
    rx_pop    = go_ack && !cur_we && is_mbox;
    tx_push   = go_ack && cur_we && is_mbox;
    err_set   = go_ack && is_err;
    rdata_nxt = '0;
    if (go_ack && !cur_we) begin
      if (is_mbox)     rdata_nxt = rx_pop_dat;
      else if (is_ram) rdata_nxt = mem[ram_idx];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      Wb_ack   <= 1'b0;
      Wb_rdata <= '0;
      Bus_err  <= 1'b0;
    end else begin
      if (state == S_IDLE && Wb_cs) begin
        cnt     <= 4'(WAIT_STATES);
        addr_q  <= Wb_addr;
        we_q    <= Wb_we;
        wdata_q <= Wb_wdata;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      Wb_ack   <= go_ack;
      Wb_rdata <= rdata_nxt;
      // A new error outranks a clear on the same edge.
      if (err_set)      Bus_err <= 1'b1;
      else if (Err_clr) Bus_err <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_idx] <= cur_wdata;
  end

  wb_mem_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push_vld (Rx_valid),
    .push_rdy (Rx_ready),
    .push_dat (Rx_data),
    .pop_vld  (rx_pop_vld),
    .pop_rdy  (rx_pop),
    .pop_dat  (rx_pop_dat)
  );

  wb_mem_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push_vld (tx_push),
    .push_rdy (tx_push_rdy),
    .push_dat (cur_wdata),
    .pop_vld  (Tx_valid),
    .pop_rdy  (Tx_ready),
    .pop_dat  (Tx_data)
  );
endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: u_dut_ws1 (WAIT_STATES=1) carries most scenarios,
// u_dut_ws0 (WAIT_STATES=0) carries the back-to-back case. Shared bus inputs,
// per-instance Wb_cs, outputs muxed by sel.
module tb_wb_mem_responder;
  localparam logic [31:0] MBOX = 32'hFFFF_FFFC;

  logic        tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic        rst_n, sel, wb_cs, wb_we, rx_valid, tx_ready, err_clr;
  logic [31:0] wb_addr, wb_wdata, rx_data;

  logic        a_ack, a_rx_ready, a_tx_valid, a_bus_err;
  logic        b_ack, b_rx_ready, b_tx_valid, b_bus_err;
  logic [31:0] a_rdata, a_tx_data, b_rdata, b_tx_data;

  logic        wb_ack, rx_ready, tx_valid, bus_err;
  logic [31:0] wb_rdata, tx_data;

  assign wb_ack   = sel ? b_ack      : a_ack;
  assign wb_rdata = sel ? b_rdata    : a_rdata;
  assign rx_ready = sel ? b_rx_ready : a_rx_ready;
  assign tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign tx_data  = sel ? b_tx_data  : a_tx_data;
  assign bus_err  = sel ? b_bus_err  : a_bus_err;

  wb_mem_responder #(.DEPTH(16), .WAIT_STATES(1), .FIFO_DEPTH(4)) u_dut_ws1 (
    .Clk(tb_clk), .Rst(rst_n), .Wb_addr(wb_addr), .Wb_cs(wb_cs && !sel), .Wb_we(wb_we),
    .Wb_wdata(wb_wdata), .Wb_rdata(a_rdata), .Wb_ack(a_ack), .Rx_valid(rx_valid),
    .Rx_data(rx_data), .Rx_ready(a_rx_ready), .Tx_valid(a_tx_valid), .Tx_data(a_tx_data),
    .Tx_ready(tx_ready), .Bus_err(a_bus_err), .Err_clr(err_clr)
  );

  wb_mem_responder #(.DEPTH(16), .WAIT_STATES(0), .FIFO_DEPTH(4)) u_dut_ws0 (
    .Clk(tb_clk), .Rst(rst_n), .Wb_addr(wb_addr), .Wb_cs(wb_cs && sel), .Wb_we(wb_we),
    .Wb_wdata(wb_wdata), .Wb_rdata(b_rdata), .Wb_ack(b_ack), .Rx_valid(rx_valid),
    .Rx_data(rx_data), .Rx_ready(b_rx_ready), .Tx_valid(b_tx_valid), .Tx_data(b_tx_data),
    .Tx_ready(tx_ready), .Bus_err(b_bus_err), .Err_clr(err_clr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns one negedge after the ack cycle so the FSM is back in IDLE.
  // lat = edges from the sampling edge to the edge that raised Wb_ack.
  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
    wb_addr  = addr;
    wb_we    = we;
    wb_wdata = wdata;
    wb_cs    = 1'b1;
    lat      = -1;
    rdata    = '0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge tb_clk);
      if (wb_ack) begin
        lat   = n - 1;
        rdata = wb_rdata;
        break;
      end
    end
    wb_cs = 1'b0;
    if (lat < 0) chk("xfer_timeout", 32'd0, 32'd1);
    @(negedge tb_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int          lat;

  initial begin
    sel = 0; rst_n = 0; wb_cs = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0; err_clr = 0;
    repeat (2) @(negedge tb_clk);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_rdata", wb_rdata, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst_n = 1;
    @(negedge tb_clk);

    // RAM write/read with one wait state
    wb_xfer(32'h10, 1'b1, 32'hDEAD_BEEF, rd, lat);
    chk("t1_wr_lat", lat, 32'd2);
    chk("t1_wr_rdata", rd, 32'd0);
    chk("t1_ack_one_cycle", {31'd0, wb_ack}, 32'd0);
    wb_xfer(32'h10, 1'b0, 32'd0, rd, lat);
    chk("t1_rd_lat", lat, 32'd2);
    chk("t1_rd_data", rd, 32'hDEAD_BEEF);
    chk("t1_rdata_idle", wb_rdata, 32'd0);
    wb_xfer(32'h3C, 1'b1, 32'h0C0F_FEE0, rd, lat);
    wb_xfer(32'h3C, 1'b0, 32'd0, rd, lat);
    chk("t1_last_word", rd, 32'h0C0F_FEE0);

    // Zero wait states, back-to-back reads with Wb_cs held
    sel = 1;
    wb_xfer(32'h0, 1'b1, 32'h0000_00A0, rd, lat);
    chk("t2_wr_lat", lat, 32'd0);
    wb_xfer(32'h4, 1'b1, 32'h0000_00A4, rd, lat);
    wb_addr = 32'h0; wb_we = 1'b0; wb_cs = 1'b1;
    @(negedge tb_clk);
    chk("t2_ack0", {31'd0, wb_ack}, 32'd1);
    chk("t2_data0", wb_rdata, 32'h0000_00A0);
    wb_addr = 32'h4;
    @(negedge tb_clk);
    chk("t2_gap", {31'd0, wb_ack}, 32'd0);
    @(negedge tb_clk);
    chk("t2_ack1", {31'd0, wb_ack}, 32'd1);
    chk("t2_data1", wb_rdata, 32'h0000_00A4);
    wb_cs = 1'b0;
    @(negedge tb_clk);
    sel = 0;

    // Mailbox read stalls on empty RX until a push lands
    wb_addr = MBOX; wb_we = 1'b0; wb_cs = 1'b1;
    repeat (5) @(negedge tb_clk);
    chk("t3_stall_noack", {31'd0, wb_ack}, 32'd0);
    rx_valid = 1'b1; rx_data = 32'd101;
    @(negedge tb_clk);
    rx_valid = 1'b0;
    chk("t3_push_edge_noack", {31'd0, wb_ack}, 32'd0);
    @(negedge tb_clk);
    chk("t3_ack", {31'd0, wb_ack}, 32'd1);
    chk("t3_data", wb_rdata, 32'd101);
    wb_cs = 1'b0;
    @(negedge tb_clk);

    // RX full: fifth push ignored, four words read back in order
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 32'd10 + 32'(i);
      @(negedge tb_clk);
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(MBOX, 1'b0, 32'd0, rd, lat);
      chk("rx_order", rd, 32'd10 + 32'(i));
    end
    chk("rx_drained_ready", {31'd0, rx_ready}, 32'd1);
    // RX now empty: the read stalls, then is aborted
    wb_addr = MBOX; wb_we = 1'b0; wb_cs = 1'b1;
    repeat (6) @(negedge tb_clk);
    chk("rx_empty_stall", {31'd0, wb_ack}, 32'd0);
    wb_cs = 1'b0;
    repeat (2) @(negedge tb_clk);
    chk("abort_noack", {31'd0, wb_ack}, 32'd0);
    rx_valid = 1'b1; rx_data = 32'd77;
    @(negedge tb_clk);
    rx_valid = 1'b0;
    wb_xfer(MBOX, 1'b0, 32'd0, rd, lat);
    chk("rx_after_abort", rd, 32'd77);

    // TX fill, stalled fifth write, ordered drain
    for (int i = 0; i < 4; i++) wb_xfer(MBOX, 1'b1, 32'd5 + 32'(i), rd, lat);
    chk("tx_valid_full", {31'd0, tx_valid}, 32'd1);
    chk("tx_head5", tx_data, 32'd5);
    wb_addr = MBOX; wb_we = 1'b1; wb_wdata = 32'd9; wb_cs = 1'b1;
    repeat (6) @(negedge tb_clk);
    chk("t4_stall_noack", {31'd0, wb_ack}, 32'd0);
    tx_ready = 1'b1;
    @(negedge tb_clk);
    tx_ready = 1'b0;
    chk("t4_pop_edge_noack", {31'd0, wb_ack}, 32'd0);
    @(negedge tb_clk);
    chk("t4_ack", {31'd0, wb_ack}, 32'd1);
    chk("t4_wr_rdata", wb_rdata, 32'd0);
    wb_cs = 1'b0;
    @(negedge tb_clk);
    for (int i = 0; i < 4; i++) begin
      chk("tx_order", tx_data, 32'd6 + 32'(i));
      tx_ready = 1'b1;
      @(negedge tb_clk);
    end
    tx_ready = 1'b0;
    chk("tx_empty_valid", {31'd0, tx_valid}, 32'd0);
    chk("tx_empty_data", tx_data, 32'd0);

    // Decode errors
    chk("t5_err_before", {31'd0, bus_err}, 32'd0);
    wb_xfer(32'h2, 1'b0, 32'd0, rd, lat);
    chk("t5_misalign_rdata", rd, 32'd0);
    chk("t5_misalign_err", {31'd0, bus_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge tb_clk);
    err_clr = 1'b0;
    chk("t5_clr", {31'd0, bus_err}, 32'd0);
    wb_xfer(32'h40, 1'b0, 32'd0, rd, lat);
    chk("t5_oor_lat", lat, 32'd2);
    chk("t5_oor_rdata", rd, 32'd0);
    chk("t5_oor_err", {31'd0, bus_err}, 32'd1);
    err_clr = 1'b1;
    wb_addr = 32'h40; wb_we = 1'b0; wb_cs = 1'b1;
    repeat (3) @(negedge tb_clk);
    chk("t5_prec_ack", {31'd0, wb_ack}, 32'd1);
    chk("t5_set_wins", {31'd0, bus_err}, 32'd1);
    wb_cs = 1'b0;
    @(negedge tb_clk);
    chk("t5_clr_after", {31'd0, bus_err}, 32'd0);
    err_clr = 1'b0;
    wb_xfer(32'h12, 1'b1, 32'hBADB_AD00, rd, lat);
    wb_xfer(32'h10, 1'b0, 32'd0, rd, lat);
    chk("t5_misalign_wr_ignored", rd, 32'hDEAD_BEEF);

    // Reset during WAIT and during STALL
    wb_xfer(32'h20, 1'b1, 32'h0000_1234, rd, lat);
    wb_addr = 32'h10; wb_we = 1'b1; wb_wdata = 32'h0000_0BAD; wb_cs = 1'b1;
    @(negedge tb_clk);
    rst_n = 1'b0; wb_cs = 1'b0;
    @(negedge tb_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge tb_clk);
    chk("t6_wait_noack", {31'd0, wb_ack}, 32'd0);
    for (int i = 0; i < 4; i++) wb_xfer(MBOX, 1'b1, 32'd1 + 32'(i), rd, lat);
    wb_addr = MBOX; wb_we = 1'b1; wb_wdata = 32'd5; wb_cs = 1'b1;
    repeat (4) @(negedge tb_clk);
    rst_n = 1'b0; wb_cs = 1'b0;
    @(negedge tb_clk);
    chk("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("t6_tx_data", tx_data, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge tb_clk);
    chk("t6_stall_noack", {31'd0, wb_ack}, 32'd0);
    wb_xfer(32'h10, 1'b0, 32'd0, rd, lat);
    chk("t6_ram_10", rd, 32'hDEAD_BEEF);
    wb_xfer(32'h20, 1'b0, 32'd0, rd, lat);
    chk("t6_ram_20", rd, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
